// File: rtl/mm_dma.sv
// mm_dma: single-channel word-copy initiator on the req/gnt/rvalid data-port protocol.
// Define MM_DMA_FILL_EN to add a fill mode that writes a latched pattern instead of copying.
module mm_dma #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 fill_i,
  input  logic [31:0]          fill_data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 data_req_o,
  output logic [31:0]          data_addr_o,
  output logic                 data_we_o,
  output logic [3:0]           data_be_o,
  output logic [31:0]          data_wdata_o,
  input  logic                 data_gnt_i,
  input  logic                 data_rvalid_i,
  input  logic [31:0]          data_rdata_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [31:0]          buf_q, buf_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;

  logic                 fill_start;
  logic                 fill_mode;
  logic [31:0]          fill_word;

`ifdef MM_DMA_FILL_EN
  logic        fill_q, fill_d;
  logic [31:0] fill_data_q, fill_data_d;

  // The pattern tracks fill_data_i until the transfer leaves IDLE.
  always_comb begin
    fill_d      = fill_q;
    fill_data_d = fill_data_q;
    if (state_q == IDLE) begin
      fill_data_d = fill_data_i;
      if (start_i) fill_d = fill_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q      <= 1'b0;
      fill_data_q <= 32'h0;
    end else begin
      fill_q      <= fill_d;
      fill_data_q <= fill_data_d;
    end
  end

  assign fill_start = fill_i;
  assign fill_mode  = fill_q;
  assign fill_word  = fill_data_q;
`else
  logic unused_fill;
  assign unused_fill = ^{fill_i, fill_data_i};
  assign fill_start  = 1'b0;
  assign fill_mode   = 1'b0;
  assign fill_word   = 32'h0;
`endif

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    done_o       = 1'b0;
    data_req_o   = 1'b0;
    data_addr_o  = 32'h0;
    data_we_o    = 1'b0;
    data_wdata_o = 32'h0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d = {src_addr_i[31:2], 2'b00};
          dst_d = {dst_addr_i[31:2], 2'b00};
          cnt_d = len_i;
          if (len_i == '0)     state_d = DONE;
          else if (fill_start) state_d = WR_REQ;
          else                 state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        data_req_o  = 1'b1;
        data_addr_o = src_q;
        if (data_gnt_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (data_rvalid_i) begin
          buf_d   = data_rdata_i;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        data_req_o   = 1'b1;
        data_we_o    = 1'b1;
        data_addr_o  = dst_q;
        data_wdata_o = fill_mode ? fill_word : buf_q;
        if (data_gnt_i) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (data_rvalid_i) begin
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) state_d = DONE;
          else if (fill_mode)         state_d = WR_REQ;
          else                        state_d = RD_REQ;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q != IDLE) && (state_q != DONE);
  assign data_be_o = data_req_o ? 4'hF : 4'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      src_q   <= 32'h0;
      dst_q   <= 32'h0;
      buf_q   <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mm_dma.sv
// Scoreboard bench for mm_dma: expected bus transactions and done cycles are queued by
// the stimulus and consumed by an independent monitor.
module tb_mm_dma;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] src_addr_i, dst_addr_i;
  logic [15:0] len_i;
  logic        fill_i;
  logic [31:0] fill_data_i;
  logic        busy_o, done_o;
  logic        data_req_o, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = 32'h0;

  always #5 clk_i = ~clk_i;

  mm_dma #(.LEN_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .fill_i(fill_i), .fill_data_i(fill_data_i),
    .busy_o(busy_o), .done_o(done_o),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   done_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  logic [31:0] mem [logic [31:0]];
  int   req_idx    = 0;
  int   stall_at   = -1;
  int   stall_left = 0;

  logic        granted;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_txn(input logic [31:0] a, input logic w, input logic [31:0] d);
    txn_t t;
    t.addr = a; t.we = w; t.wdata = d;
    exp_q.push_back(t);
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Responder: grants in the request cycle (unless stalled), rvalid one cycle after grant.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      granted   <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= 32'h0;
      cap_wdata <= 32'h0;
    end else begin
      granted   <= data_req_o && data_gnt_i;
      cap_we    <= data_we_o;
      cap_addr  <= data_addr_o;
      cap_wdata <= data_wdata_o;
    end
  end

  always @(negedge clk_i) begin
    data_rvalid_i = granted;
    data_rdata_i  = 32'h0;
    if (granted) begin
      if (cap_we) mem[cap_addr] = cap_wdata;
      else if (mem.exists(cap_addr)) data_rdata_i = mem[cap_addr];
    end
    data_gnt_i = 1'b0;
    if (data_req_o && rst_ni) begin
      if (req_idx == stall_at && stall_left > 0) stall_left--;
      else begin
        data_gnt_i = 1'b1;
        req_idx++;
      end
    end
  end

  // Monitor: checks every request cycle against the queue head, pops on grant.
  always @(negedge clk_i) begin
    txn_t e;
    #1;
    if (rst_ni) begin
      if (data_req_o) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL bus_unexpected: got addr 0x%08h we %0b, expected no request", data_addr_o, data_we_o);
        end else begin
          e = exp_q[0];
          chk("bus_addr", data_addr_o, e.addr);
          chk("bus_we", {31'h0, data_we_o}, {31'h0, e.we});
          chk("bus_be", {28'h0, data_be_o}, 32'hF);
          if (e.we) chk("bus_wdata", data_wdata_o, e.wdata);
          if (data_gnt_i) void'(exp_q.pop_front());
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL done_unexpected: got done_o=1 at cyc %0d, expected none", cyc);
        end else begin
          chk("done_cycle", cyc, done_q.pop_front());
          chk("busy_at_done", {31'h0, busy_o}, 32'h0);
        end
      end
    end
  end

  // Start a transfer; done is expected in cycle done_cycle counted from the sampling edge.
  task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                    input logic f, input int done_cycle);
    @(negedge clk_i);
    src_addr_i = s; dst_addr_i = d; len_i = n; fill_i = f; start_i = 1'b1;
    done_q.push_back(cyc + done_cycle);
    @(negedge clk_i);
    start_i = 1'b0;
    src_addr_i = 32'hDEAD_0000; dst_addr_i = 32'hBEEF_0000; len_i = 16'h7;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done_q.size() != 0 && k < 300) begin
      @(negedge clk_i);
      k++;
    end
    if (k >= 300) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got %0d pending done, expected 0", name, done_q.size());
      done_q.delete();
    end
    repeat (2) @(negedge clk_i);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int bad;
    rst_ni = 1'b0; start_i = 1'b0; src_addr_i = 0; dst_addr_i = 0; len_i = 0;
    fill_i = 1'b0; fill_data_i = 32'h0;
    mem[32'h100] = 32'hCAFE_0001; mem[32'h104] = 32'hCAFE_0002;
    mem[32'h108] = 32'hCAFE_0003; mem[32'h10C] = 32'hCAFE_0004;
    mem[32'h000] = 32'h0BAD_0000; mem[32'h004] = 32'h0BAD_0004;
    mem[32'h300] = 32'h1234_5678; mem[32'h304] = 32'h9ABC_DEF0;
    mem[32'h500] = 32'h5555_0000; mem[32'h504] = 32'h5555_0004;
    repeat (3) @(negedge clk_i);
    #2;
    chk("reset_outputs",
        {busy_o, done_o, data_req_o, data_we_o, data_be_o, data_addr_o[23:0]}, 32'h0);
    chk("reset_wdata", data_wdata_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // 4-word copy
    push_txn(32'h100, 0, 0); push_txn(32'h200, 1, 32'hCAFE_0001);
    push_txn(32'h104, 0, 0); push_txn(32'h204, 1, 32'hCAFE_0002);
    push_txn(32'h108, 0, 0); push_txn(32'h208, 1, 32'hCAFE_0003);
    push_txn(32'h10C, 0, 0); push_txn(32'h20C, 1, 32'hCAFE_0004);
    go(32'h100, 32'h200, 16'd4, 1'b0, 17);
    wait_done("copy4");

    // len=0: no bus activity, done in cycle 1, never busy
    go(32'h40, 32'h80, 16'd0, 1'b0, 1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      if (busy_o || data_req_o) bad++;
      @(negedge clk_i);
    end
    chk("len0_quiet", bad, 0);
    wait_done("len0");

    // 3-cycle grant stall on the second read, unaligned source
    push_txn(32'h000, 0, 0); push_txn(32'h010, 1, 32'h0BAD_0000);
    push_txn(32'h004, 0, 0); push_txn(32'h014, 1, 32'h0BAD_0004);
    stall_at = req_idx + 2; stall_left = 3;
    go(32'h3, 32'h11, 16'd2, 1'b0, 12);
    wait_done("stall");
    stall_at = -1;

    // start_i pulsed mid-transfer is ignored
    push_txn(32'h300, 0, 0); push_txn(32'h380, 1, 32'h1234_5678);
    push_txn(32'h304, 0, 0); push_txn(32'h384, 1, 32'h9ABC_DEF0);
    go(32'h300, 32'h380, 16'd2, 1'b0, 9);
    repeat (2) @(negedge clk_i);
    src_addr_i = 32'h500; dst_addr_i = 32'h600; len_i = 16'd5; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done("restart_ignored");

    // Reset during WR_WAIT of word 2 (cycle 8)
    push_txn(32'h500, 0, 0); push_txn(32'h700, 1, 32'h5555_0000);
    push_txn(32'h504, 0, 0); push_txn(32'h704, 1, 32'h5555_0004);
    go(32'h500, 32'h700, 16'd2, 1'b0, 9);
    repeat (7) @(negedge clk_i);
    rst_ni = 1'b0;
    done_q.delete();
    #1;
    chk("abort_outputs",
        {busy_o, done_o, data_req_o, data_we_o, data_be_o, data_addr_o[23:0]}, 32'h0);
    chk("abort_wdata", data_wdata_o, 32'h0);
    chk("abort_all_granted", exp_q.size(), 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    push_txn(32'h100, 0, 0); push_txn(32'h280, 1, 32'hCAFE_0001);
    go(32'h100, 32'h280, 16'd1, 1'b0, 5);
    wait_done("after_reset");

`ifdef MM_DMA_FILL_EN
    // Fill across the 32-bit address wrap
    fill_data_i = 32'hDEAD_BEEF;
    push_txn(32'hFFFF_FFF8, 1, 32'hDEAD_BEEF);
    push_txn(32'hFFFF_FFFC, 1, 32'hDEAD_BEEF);
    push_txn(32'h0000_0000, 1, 32'hDEAD_BEEF);
    go(32'h100, 32'hFFFF_FFF8, 16'd3, 1'b1, 7);
    fill_i = 1'b0;
    wait_done("fill");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 time units, expected completion");
    $fatal(1);
  end

endmodule
